// File: rtl/multi_cycle_control_if.sv
// Control bus between the multi-cycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multi_cycle_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic             zero;
    logic             PCWre;
    logic             IRWre;
    logic             InsMemRW;
    logic             ExtSel;
    logic             RegOut;
    logic             RegWre;
    logic [2:0]       ALUOp;
    logic             ALUSrcB;
    logic             ALUM2Reg;
    logic             DataMemRW;
    logic [1:0]       PCSrc;
    logic [2:0]       state;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] inst_count;

    modport master (
        input  opcode, zero,
        output PCWre, IRWre, InsMemRW, ExtSel, RegOut, RegWre,
        output ALUOp, ALUSrcB, ALUM2Reg, DataMemRW, PCSrc,
        output state, halted, illegal, inst_count
    );

    modport slave (
        output opcode, zero,
        input  PCWre, IRWre, InsMemRW, ExtSel, RegOut, RegWre,
        input  ALUOp, ALUSrcB, ALUM2Reg, DataMemRW, PCSrc,
        input  state, halted, illegal, inst_count
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU controller: IF/ID/EXE/MEM/WB sequencing, datapath
// enables and selects, retired-instruction counter, sticky illegal flag.
module multi_cycle_control #(
    parameter int CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   Reset,
    multi_cycle_control_if.master  bus
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal;

    logic w_add, w_addi, w_sub, w_ori, w_and, w_or, w_move;
    logic w_sw, w_lw, w_beq, w_j, w_halt, w_ill;
    logic w_alu;

    logic       w_pcwre;
    logic       w_irwre;
    logic       w_regwre;
    logic       w_dmw;
    logic       w_m2r;
    logic [1:0] w_pcsrc;
    logic       w_extsel;
    logic       w_regout;
    logic       w_srcb;
    logic [2:0] w_aluop;

    // Opcode classification
    always_comb begin
        w_add  = 1'b0;
        w_addi = 1'b0;
        w_sub  = 1'b0;
        w_ori  = 1'b0;
        w_and  = 1'b0;
        w_or   = 1'b0;
        w_move = 1'b0;
        w_sw   = 1'b0;
        w_lw   = 1'b0;
        w_beq  = 1'b0;
        w_j    = 1'b0;
        w_halt = 1'b0;
        w_ill  = 1'b0;
        case (bus.opcode)
            6'b000000: w_add  = 1'b1;
            6'b000001: w_addi = 1'b1;
            6'b000010: w_sub  = 1'b1;
            6'b010000: w_ori  = 1'b1;
            6'b010001: w_and  = 1'b1;
            6'b010010: w_or   = 1'b1;
            6'b100000: w_move = 1'b1;
            6'b100110: w_sw   = 1'b1;
            6'b100111: w_lw   = 1'b1;
            6'b110000: w_beq  = 1'b1;
            6'b111000: w_j    = 1'b1;
            6'b111111: w_halt = 1'b1;
            default:   w_ill  = 1'b1;
        endcase
    end

    assign w_alu = w_add | w_addi | w_sub | w_ori
                 | w_and | w_or | w_move;

    // Next-state logic
    always_comb begin
        w_next = S_IF;
        unique case (r_state)
            S_IF:   w_next = S_ID;
            S_ID: begin
                unique case (1'b1)
                    w_halt:       w_next = S_HALT;
                    w_j | w_ill:  w_next = S_IF;
                    default:      w_next = S_EXE;
                endcase
            end
            S_EXE: begin
                unique case (1'b1)
                    w_beq:        w_next = S_IF;
                    w_sw | w_lw:  w_next = S_MEM;
                    default:      w_next = S_WB;
                endcase
            end
            S_MEM:  w_next = w_lw ? S_WB : S_IF;
            S_WB:   w_next = S_IF;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IF;
        endcase
    end

    // Per-state enables before the reset gate
    always_comb begin
        w_pcwre  = 1'b0;
        w_irwre  = 1'b0;
        w_regwre = 1'b0;
        w_dmw    = 1'b0;
        w_m2r    = 1'b0;
        w_pcsrc  = 2'b00;
        unique case (r_state)
            S_IF:  w_irwre = 1'b1;
            S_ID: begin
                w_pcwre = w_j | w_ill;
                if (w_j) w_pcsrc = 2'b10;
            end
            S_EXE: begin
                w_pcwre = w_beq;
                if (w_beq && bus.zero) w_pcsrc = 2'b01;
            end
            S_MEM: begin
                w_pcwre = w_sw;
                w_dmw   = w_sw;
            end
            S_WB: begin
                w_pcwre  = 1'b1;
                w_regwre = 1'b1;
                w_m2r    = w_lw;
            end
            default: ;
        endcase
    end

    // Opcode-only decode, valid in every state
    always_comb begin
        w_extsel = ~(w_ori | w_and | w_or);
        w_regout = w_add | w_sub | w_and | w_or | w_move;
        w_srcb   = w_addi | w_ori | w_sw | w_lw;
        w_aluop  = 3'b000;
        unique case (1'b1)
            w_sub | w_beq: w_aluop = 3'b001;
            w_ori | w_or:  w_aluop = 3'b011;
            w_and:         w_aluop = 3'b100;
            default:       w_aluop = 3'b000;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_cnt <= '0;
        end else if (w_pcwre) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_illegal <= 1'b0;
        end else if (r_state == S_ID && w_ill) begin
            r_illegal <= 1'b1;
        end
    end

    // Write enables are held off while Reset is low
    assign bus.PCWre      = w_pcwre & Reset;
    assign bus.IRWre      = w_irwre & Reset;
    assign bus.RegWre     = w_regwre & Reset;
    assign bus.DataMemRW  = w_dmw & Reset;
    assign bus.InsMemRW   = 1'b0;
    assign bus.ALUM2Reg   = w_m2r;
    assign bus.PCSrc      = w_pcsrc;
    assign bus.ExtSel     = w_extsel;
    assign bus.RegOut     = w_regout;
    assign bus.ALUSrcB    = w_srcb;
    assign bus.ALUOp      = w_aluop;
    assign bus.state      = r_state;
    assign bus.halted     = (r_state == S_HALT);
    assign bus.illegal    = r_illegal;
    assign bus.inst_count = r_cnt;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: vector table plus corner sequences.
module tb_multi_cycle_control;

    localparam int W = 8;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_BAD  = 6'b101010;

    // ctl = {PCWre, IRWre, RegWre, DataMemRW, ALUM2Reg, PCSrc}
    localparam logic [6:0] C_IF  = 7'b0100000;
    localparam logic [6:0] C_0   = 7'b0000000;
    localparam logic [6:0] C_WB  = 7'b1010000;
    localparam logic [6:0] C_LWB = 7'b1010100;
    localparam logic [6:0] C_SWM = 7'b1001000;
    localparam logic [6:0] C_BQT = 7'b1000001;
    localparam logic [6:0] C_BQN = 7'b1000000;
    localparam logic [6:0] C_JID = 7'b1000010;

    // dec = {ALUOp, ALUSrcB, ExtSel, RegOut}
    localparam logic [5:0] D_ADD = 6'b000011;
    localparam logic [5:0] D_SUB = 6'b001011;
    localparam logic [5:0] D_ORI = 6'b011100;
    localparam logic [5:0] D_AND = 6'b100001;
    localparam logic [5:0] D_OR  = 6'b011001;
    localparam logic [5:0] D_MEM = 6'b000110;
    localparam logic [5:0] D_BEQ = 6'b001010;
    localparam logic [5:0] D_J   = 6'b000010;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic [2:0] st;
        logic [6:0] ctl;
        logic [5:0] dec;
    } vec_t;

    logic CLK;
    logic Reset;
    int   checks;
    int   errors;
    vec_t vecs[$];

    multi_cycle_control_if #(.CNT_W(W)) bus ();

    multi_cycle_control #(.CNT_W(W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic v(input logic [5:0] op, input logic z,
                     input logic [2:0] st, input logic [6:0] ctl,
                     input logic [5:0] dec);
        vec_t e;
        e = '{op, z, st, ctl, dec};
        vecs.push_back(e);
    endtask

    function automatic logic [6:0] ctl_now();
        return {bus.PCWre, bus.IRWre, bus.RegWre, bus.DataMemRW,
                bus.ALUM2Reg, bus.PCSrc};
    endfunction

    function automatic logic [5:0] dec_now();
        return {bus.ALUOp, bus.ALUSrcB, bus.ExtSel, bus.RegOut};
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        v(OP_ADD, 0, 3'd0, C_IF,  D_ADD);
        v(OP_ADD, 0, 3'd1, C_0,   D_ADD);
        v(OP_ADD, 1, 3'd2, C_0,   D_ADD);
        v(OP_ADD, 0, 3'd4, C_WB,  D_ADD);
        v(OP_SUB, 0, 3'd0, C_IF,  D_SUB);
        v(OP_SUB, 0, 3'd1, C_0,   D_SUB);
        v(OP_SUB, 0, 3'd2, C_0,   D_SUB);
        v(OP_SUB, 0, 3'd4, C_WB,  D_SUB);
        v(OP_OR,  0, 3'd0, C_IF,  D_OR);
        v(OP_OR,  0, 3'd1, C_0,   D_OR);
        v(OP_OR,  0, 3'd2, C_0,   D_OR);
        v(OP_OR,  0, 3'd4, C_WB,  D_OR);
        v(OP_ORI, 0, 3'd0, C_IF,  D_ORI);
        v(OP_ORI, 0, 3'd1, C_0,   D_ORI);
        v(OP_ORI, 0, 3'd2, C_0,   D_ORI);
        v(OP_ORI, 0, 3'd4, C_WB,  D_ORI);
        v(OP_AND, 0, 3'd0, C_IF,  D_AND);
        v(OP_AND, 0, 3'd1, C_0,   D_AND);
        v(OP_AND, 1, 3'd2, C_0,   D_AND);
        v(OP_AND, 0, 3'd4, C_WB,  D_AND);
        v(OP_LW,  0, 3'd0, C_IF,  D_MEM);
        v(OP_LW,  0, 3'd1, C_0,   D_MEM);
        v(OP_LW,  0, 3'd2, C_0,   D_MEM);
        v(OP_LW,  0, 3'd3, C_0,   D_MEM);
        v(OP_LW,  0, 3'd4, C_LWB, D_MEM);
        v(OP_BEQ, 1, 3'd0, C_IF,  D_BEQ);
        v(OP_BEQ, 1, 3'd1, C_0,   D_BEQ);
        v(OP_BEQ, 1, 3'd2, C_BQT, D_BEQ);
        v(OP_BEQ, 0, 3'd0, C_IF,  D_BEQ);
        v(OP_BEQ, 0, 3'd1, C_0,   D_BEQ);
        v(OP_BEQ, 0, 3'd2, C_BQN, D_BEQ);
        v(OP_SW,  0, 3'd0, C_IF,  D_MEM);
        v(OP_SW,  0, 3'd1, C_0,   D_MEM);
        v(OP_SW,  0, 3'd2, C_0,   D_MEM);
        v(OP_SW,  0, 3'd3, C_SWM, D_MEM);
        v(OP_J,   0, 3'd0, C_IF,  D_J);
        v(OP_J,   0, 3'd1, C_JID, D_J);

        // Reset held low for three cycles
        Reset      = 1'b0;
        bus.opcode = OP_ADD;
        bus.zero   = 1'b0;
        repeat (3) tick();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_count", 32'(bus.inst_count), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_ctl", 32'(ctl_now()), 32'(C_0));
        chk("rst_insmem", 32'(bus.InsMemRW), 32'd0);
        Reset = 1'b1;

        foreach (vecs[i]) begin
            bus.opcode = vecs[i].op;
            bus.zero   = vecs[i].z;
            #1;
            chk($sformatf("v%0d_state", i), 32'(bus.state),
                32'(vecs[i].st));
            chk($sformatf("v%0d_ctl", i), 32'(ctl_now()),
                32'(vecs[i].ctl));
            chk($sformatf("v%0d_dec", i), 32'(dec_now()),
                32'(vecs[i].dec));
            tick();
        end
        chk("after_table_state", 32'(bus.state), 32'd0);
        chk("after_table_count", 32'(bus.inst_count), 32'd10);
        chk("after_table_halted", 32'(bus.halted), 32'd0);

        // Undefined opcode retires as a NOP and sets the sticky flag
        bus.opcode = OP_BAD;
        tick();
        chk("bad_id_state", 32'(bus.state), 32'd1);
        chk("bad_id_pcwre", 32'(bus.PCWre), 32'd1);
        chk("bad_id_dec", 32'(dec_now()), 32'(D_J));
        tick();
        chk("bad_next_state", 32'(bus.state), 32'd0);
        chk("bad_illegal", 32'(bus.illegal), 32'd1);
        chk("bad_count", 32'(bus.inst_count), 32'd11);
        bus.opcode = OP_ADD;
        repeat (4) tick();
        chk("add2_state", 32'(bus.state), 32'd0);
        chk("add2_illegal", 32'(bus.illegal), 32'd1);
        chk("add2_count", 32'(bus.inst_count), 32'd12);

        // halt parks the controller
        bus.opcode = OP_HALT;
        tick();
        chk("halt_id_state", 32'(bus.state), 32'd1);
        chk("halt_id_pcwre", 32'(bus.PCWre), 32'd0);
        tick();
        for (int k = 0; k < 10; k++) begin
            bus.zero = k[0];
            #1;
            chk($sformatf("halt%0d_state", k), 32'(bus.state), 32'd5);
            chk($sformatf("halt%0d_halted", k), 32'(bus.halted), 32'd1);
            chk($sformatf("halt%0d_pcwre", k), 32'(bus.PCWre), 32'd0);
            tick();
        end
        chk("halt_count", 32'(bus.inst_count), 32'd12);

        // Only Reset leaves HALT
        Reset = 1'b0;
        #1;
        chk("unhalt_state", 32'(bus.state), 32'd0);
        chk("unhalt_halted", 32'(bus.halted), 32'd0);
        #2;
        Reset = 1'b1;
        bus.zero = 1'b0;

        // Reset asserted in the MEM cycle of sw
        bus.opcode = OP_SW;
        repeat (3) tick();
        chk("swm_state", 32'(bus.state), 32'd3);
        chk("swm_dmw", 32'(bus.DataMemRW), 32'd1);
        chk("swm_count", 32'(bus.inst_count), 32'd0);
        Reset = 1'b0;
        #1;
        chk("swrst_state", 32'(bus.state), 32'd0);
        chk("swrst_dmw", 32'(bus.DataMemRW), 32'd0);
        chk("swrst_pcwre", 32'(bus.PCWre), 32'd0);
        chk("swrst_count", 32'(bus.inst_count), 32'd0);
        chk("swrst_illegal", 32'(bus.illegal), 32'd0);
        #2;
        Reset = 1'b1;

        // Counter wrap: all-ones then zero
        bus.opcode = OP_J;
        for (int k = 0; k < (1 << W) - 1; k++) begin
            tick();
            tick();
        end
        chk("wrap_full", 32'(bus.inst_count), 32'((1 << W) - 1));
        tick();
        tick();
        chk("wrap_zero", 32'(bus.inst_count), 32'd0);
        chk("wrap_state", 32'(bus.state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
